// File: rtl/act_lut_pkg.sv
// Shared constants and helpers for the activation LUT interpolator: reset ramp,
// flat-top/wrap successor index, and signed saturation.
package act_lut_pkg;

  localparam int unsigned DataWDefault = 8;
  localparam int unsigned AddrWDefault = 4;

  // Reset value of entry idx: idx placed in the top bits, caller truncates to DATA_W.
  function automatic logic [31:0] ramp_entry(input int unsigned idx, input int unsigned frac_w);
    return 32'(idx << frac_w);
  endfunction

  // The most positive segment is flat; every other index steps up, wrapping at the top.
  function automatic int unsigned next_index(input int unsigned addr, input int unsigned addr_w);
    int unsigned max_pos;
    int unsigned mask;
    max_pos = (32'd1 << (addr_w - 1)) - 32'd1;
    mask    = (32'd1 << addr_w) - 32'd1;
    if (addr == max_pos) begin
      return addr;
    end
    return (addr + 32'd1) & mask;
  endfunction

  function automatic int signed sat(input int signed sum, input int unsigned data_w);
    int signed hi;
    int signed lo;
    hi = (1 <<< (data_w - 1)) - 1;
    lo = -(1 <<< (data_w - 1));
    if (sum > hi) begin
      return hi;
    end
    if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/act_lut_interp_if.sv
// Sample/result handshake and table write port of the activation LUT interpolator.
interface act_lut_interp_if
  import act_lut_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADDR_W = AddrWDefault
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic              interp_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output in_valid, in_x, interp_en, out_ready, wr_en, wr_addr, wr_data,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, interp_en, out_ready, wr_en, wr_addr, wr_data,
    output in_ready, out_valid, out_y
  );

endinterface

// File: rtl/act_lut_table.sv
// Runtime-writable activation table: one write port, two combinational read ports
// (base entry and its successor). Reset reloads the identity ramp.
module act_lut_table
  import act_lut_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] base_o,
  output logic [DATA_W-1:0] next_o
);

  localparam int unsigned FracW = DATA_W - ADDR_W;
  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];
  logic [ADDR_W-1:0] next_addr;

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_addr_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= DATA_W'(ramp_entry(i, FracW));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the pre-write contents, so a same-cycle write is invisible to S1.
  assign next_addr = ADDR_W'(next_index(32'(rd_addr_i), ADDR_W));
  assign base_o    = mem_q[rd_addr_i];
  assign next_o    = mem_q[next_addr];

endmodule

// File: rtl/act_lut_interp.sv
// Three-stage activation unit: table lookup, slope multiply, shift/add/saturate.
// A single global enable stalls every stage together when the output is blocked.
module act_lut_interp
  import act_lut_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned ADDR_W = AddrWDefault
) (
  input logic              clk,
  input logic              rst_n,
  act_lut_interp_if.slave  bus
);

  localparam int unsigned FracW = DATA_W - ADDR_W;
  localparam int unsigned ProdW = DATA_W + FracW + 2;

  logic              en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] base_rd;
  logic [DATA_W-1:0] next_rd;

  // S1
  logic              v1_q, v1_d;
  logic [DATA_W-1:0] base1_q, base1_d;
  logic [DATA_W-1:0] next1_q, next1_d;
  logic [FracW-1:0]  frac1_q, frac1_d;
  logic              ie1_q, ie1_d;
  // S2
  logic              v2_q, v2_d;
  logic [DATA_W-1:0] base2_q, base2_d;
  logic [ProdW-1:0]  prod2_q, prod2_d;
  logic              ie2_q, ie2_d;
  // S3
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_y_q, out_y_d;

  logic signed [DATA_W:0]   diff;
  logic signed [ProdW-1:0]  prod;
  logic signed [DATA_W:0]   delta;
  logic signed [DATA_W:0]   sum;
  logic        [DATA_W-1:0] y_sat;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y    = out_y_q;
  assign rd_addr      = bus.in_x[DATA_W-1 -: ADDR_W];

  act_lut_table #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_addr_i (rd_addr),
    .base_o    (base_rd),
    .next_o    (next_rd)
  );

  // Fraction is unsigned, so it gets a zero sign bit before the signed multiply.
  always_comb begin
    diff  = $signed({next1_q[DATA_W-1], next1_q}) - $signed({base1_q[DATA_W-1], base1_q});
    prod  = ProdW'(diff) * ProdW'($signed({1'b0, frac1_q}));
    delta = ie2_q ? (DATA_W + 1)'($signed(prod2_q) >>> FracW) : '0;
    sum   = $signed({base2_q[DATA_W-1], base2_q}) + delta;
    y_sat = DATA_W'(sat(int'(sum), DATA_W));
  end

  always_comb begin
    v1_d        = v1_q;
    base1_d     = base1_q;
    next1_d     = next1_q;
    frac1_d     = frac1_q;
    ie1_d       = ie1_q;
    v2_d        = v2_q;
    base2_d     = base2_q;
    prod2_d     = prod2_q;
    ie2_d       = ie2_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    if (en) begin
      v1_d        = bus.in_valid;
      base1_d     = base_rd;
      next1_d     = next_rd;
      frac1_d     = bus.in_x[FracW-1:0];
      ie1_d       = bus.interp_en;
      v2_d        = v1_q;
      base2_d     = base1_q;
      prod2_d     = prod;
      ie2_d       = ie1_q;
      out_valid_d = v2_q;
      if (v2_q) begin
        out_y_d = y_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      base1_q     <= '0;
      next1_q     <= '0;
      frac1_q     <= '0;
      ie1_q       <= 1'b0;
      v2_q        <= 1'b0;
      base2_q     <= '0;
      prod2_q     <= '0;
      ie2_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      v1_q        <= v1_d;
      base1_q     <= base1_d;
      next1_q     <= next1_d;
      frac1_q     <= frac1_d;
      ie1_q       <= ie1_d;
      v2_q        <= v2_d;
      base2_q     <= base2_d;
      prod2_q     <= prod2_d;
      ie2_q       <= ie2_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
    end
  end

endmodule

// File: tb/tb_act_lut_interp.sv
// Self-checking bench for act_lut_interp: directed vectors, write/stall/reset sequences,
// and random traffic scored against a plain-arithmetic model of the table unit.
module tb_act_lut_interp;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int FW    = DW - AW;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  act_lut_interp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  act_lut_interp #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic signed [DW-1:0] mtbl [DEPTH];
  int                   expq [$];
  logic                 prev_stall = 1'b0;
  logic [DW-1:0]        prev_y;

  typedef struct {
    logic [DW-1:0] x;
    logic          ie;
    int            exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void ramp_model();
    for (int i = 0; i < DEPTH; i++) mtbl[i] = DW'(i * (1 << FW));
  endfunction

  function automatic int floor_div(input int p, input int d);
    if (p >= 0) return p / d;
    return -((-p + d - 1) / d);
  endfunction

  // Straight-line arithmetic from the segment rule: base + floor(slope * frac).
  function automatic int model_y(input logic [DW-1:0] x, input logic ie);
    int addr, frac, nxt, base, nv, s, hi, lo;
    addr = int'(x) / (1 << FW);
    frac = int'(x) % (1 << FW);
    nxt  = (addr == DEPTH / 2 - 1) ? addr : (addr + 1) % DEPTH;
    base = int'(mtbl[addr]);
    nv   = int'(mtbl[nxt]);
    s    = base + (ie ? floor_div((nv - base) * frac, 1 << FW) : 0);
    hi   = (1 << (DW - 1)) - 1;
    lo   = -(1 << (DW - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  // Mid-cycle monitor: scoreboard, stall stability and ready rule.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      ramp_model();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
      if (prev_stall) begin
        check("stall_valid_held", int'(bus.out_valid), 1);
        check("stall_y_held", int'(bus.out_y), int'(prev_y));
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (expq.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          check("scoreboard_y", int'($signed(bus.out_y)), expq.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) expq.push_back(model_y(bus.in_x, bus.interp_en));
      if (bus.wr_en) mtbl[bus.wr_addr] = bus.wr_data;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y     = bus.out_y;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // Called at posedge+1 with an empty pipeline and out_ready=1.
  task automatic run_vec(input string name, input logic [DW-1:0] x, input logic ie,
                         input int exp, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd);
    bus.in_valid  = 1'b1;
    bus.in_x      = x;
    bus.interp_en = ie;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b0;
    check({name, "_lat1"}, int'(bus.out_valid), 0);
    @(posedge clk); #1;
    check({name, "_lat2"}, int'(bus.out_valid), 0);
    @(posedge clk); #1;
    check({name, "_valid"}, int'(bus.out_valid), 1);
    check({name, "_y"}, int'($signed(bus.out_y)), exp);
    @(posedge clk); #1;
  endtask

  task automatic write_entry(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    bus.in_valid  = 1'b0;
    bus.wr_en     = 1'b0;
    bus.out_ready = 1'b1;
    while ((expq.size() != 0 || bus.out_valid) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, expq.size(), 0);
  endtask

  initial begin
    logic [DW-1:0] bp_x [5];
    int            n0;
    logic          acc;
    int            guard;

    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.interp_en = 1'b1;
    bus.out_ready = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;

    vecs[0] = '{x: 8'd53,  ie: 1'b1, exp: 53};
    vecs[1] = '{x: 8'hFF,  ie: 1'b1, exp: -1};
    vecs[2] = '{x: 8'h80,  ie: 1'b1, exp: -128};
    vecs[3] = '{x: 8'd127, ie: 1'b1, exp: 112};
    vecs[4] = '{x: 8'd112, ie: 1'b1, exp: 112};
    vecs[5] = '{x: 8'd53,  ie: 1'b0, exp: 48};
    vecs[6] = '{x: 8'hFF,  ie: 1'b0, exp: -16};
    vecs[7] = '{x: 8'd56,  ie: 1'b1, exp: 56};
    vecs[8] = '{x: 8'h88,  ie: 1'b1, exp: -120};
    vecs[9] = '{x: 8'd0,   ie: 1'b1, exp: 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_y", int'(bus.out_y), 0);
    check("reset_in_ready", int'(bus.in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].x, vecs[i].ie, vecs[i].exp, 1'b0, '0, '0);
    end

    write_entry(4'd3, 8'd100);
    run_vec("write_t3", 8'd56, 1'b1, 82, 1'b0, '0, '0);
    write_entry(4'd3, 8'd48);
    run_vec("same_cycle_wr", 8'd56, 1'b1, 56, 1'b1, 4'd3, 8'd100);
    run_vec("after_wr", 8'd56, 1'b1, 82, 1'b0, '0, '0);
    write_entry(4'd3, 8'd48);

    // Backpressure: five back-to-back offers against six blocked cycles.
    bp_x[0] = 8'd53; bp_x[1] = 8'hFF; bp_x[2] = 8'h80; bp_x[3] = 8'd127; bp_x[4] = 8'h38;
    n0 = n_out;
    bus.out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_out_valid_high", int'(bus.out_valid), 1);
        check("bp_in_ready_low", int'(bus.in_ready), 0);
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          bus.in_valid  = 1'b1;
          bus.in_x      = bp_x[k];
          bus.interp_en = 1'b1;
          acc   = 1'b0;
          guard = 0;
          while (!acc && guard < 40) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            guard++;
          end
          if (!acc) check("bp_accept_timeout", 0, 1);
        end
        bus.in_valid = 1'b0;
      end
    join
    drain("bp_drain");
    check("bp_count", n_out - n0, 5);

    // Random traffic with stalls and table writes.
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_x      = DW'($urandom);
      bus.interp_en = 1'($urandom);
      bus.out_ready = ($urandom % 4) != 0;
      bus.wr_en     = ($urandom % 8) == 0;
      bus.wr_addr   = AW'($urandom);
      bus.wr_data   = DW'($urandom);
      @(posedge clk); #1;
    end
    drain("rand_drain");

    // Reset with three samples in flight.
    write_entry(4'd3, 8'd100);
    bus.in_valid  = 1'b1;
    bus.interp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.in_x = DW'(8'd20 + k);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("pre_reset_valid", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", int'(bus.out_valid), 0);
    check("async_reset_y", int'(bus.out_y), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", int'(bus.out_valid), 0);
    run_vec("ramp_restored", 8'd56, 1'b1, 56, 1'b0, '0, '0);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
